// File: rtl/apb_pkg.sv
// Shared types and helpers for the parametrised APB memory slave.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   localparam int DFLT_DATA_W = 32;
   localparam int STRB_W      = DFLT_DATA_W / 8;

   // Ceiling log2; returns 0 for values of 1 or less.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/apb_mem_slave_param_if.sv
// APB completer-side bus bundle for the memory slave.
interface apb_mem_slave_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [DATA_W-1:0]     pwdata;
   logic [DATA_W/8-1:0]   pstrb;
   logic [DATA_W-1:0]     prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_mem_bank.sv
// DEPTH x DATA_W storage with per-byte write enables and a registered read port.
module apb_mem_bank #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = 8
) (
   input  logic                  clk,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_en,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_W-1:0]     rd_data
);
   localparam int LANES = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < LANES; b++) begin
         if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
      if (rd_en) rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/apb_mem_slave_param.sv
// Parametrised APB scratch/config RAM slave with wait states, byte strobes and range error.
module apb_mem_slave_param
   import apb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 12,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                   pclk,
   input  logic                   preset,
   apb_mem_slave_param_if.slave   bus,
   output state_e                 dbg_state
);
   // Handshake: a transfer is psel&!penable (setup) followed by psel&penable
   // held until pready=1; pslverr and prdata are meaningful only with pready.
   localparam int LANES   = DATA_W / 8;
   localparam int LANE_SH = clog2(LANES);
   localparam int IDX_W   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
   localparam int CNT_W   = 4;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q;
   logic               write_q;
   logic               err_q;

   logic [ADDR_W-1:0]  word_addr;
   logic               err_now;
   logic               capture;
   logic               complete;
   logic [LANES-1:0]   wr_be;
   logic [DATA_W-1:0]  rd_data;

   assign word_addr = bus.paddr >> LANE_SH;
   assign err_now   = ({1'b0, word_addr} >= DEPTH_X);

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            idx_q   <= word_addr[IDX_W-1:0];
            write_q <= bus.pwrite;
            err_q   <= err_now;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      capture  = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.psel && !bus.penable) state_d = SETUP;
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(WAIT_STATES);
            capture = 1'b1;
         end
         ACCESS: begin
            // Dropping psel mid-access abandons the transfer without a response.
            if (!bus.psel) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               complete = 1'b1;
               state_d  = (bus.psel && !bus.penable) ? SETUP : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign wr_be = (complete && write_q && !err_q && bus.psel && bus.penable)
                  ? bus.pstrb : '0;

   apb_mem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_bank (
      .clk     (pclk),
      .wr_be   (wr_be),
      .wr_idx  (idx_q),
      .wr_data (bus.pwdata),
      .rd_en   (capture && !err_now),
      .rd_idx  (word_addr[IDX_W-1:0]),
      .rd_data (rd_data)
   );

   assign bus.pready  = complete;
   assign bus.pslverr = complete && err_q;
   assign bus.prdata  = (complete && !write_q && !err_q) ? rd_data : '0;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_mem_slave_param.sv
// Directed bench for apb_mem_slave_param: table of transfers plus reset/wait/abort sequences.
module tb_apb_mem_slave_param;
   import apb_pkg::*;

   logic        pclk;
   logic        preset;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   int unsigned sel;

   int tests;
   int failed;

   apb_mem_slave_param_if #(.DATA_W(32), .ADDR_W(12)) bus0 ();
   apb_mem_slave_param_if #(.DATA_W(32), .ADDR_W(12)) bus2 ();
   apb_mem_slave_param_if #(.DATA_W(32), .ADDR_W(12)) bus3 ();

   state_e st0, st2, st3;

   assign bus0.psel = psel && (sel == 0);
   assign bus2.psel = psel && (sel == 2);
   assign bus3.psel = psel && (sel == 3);
   assign bus0.penable = penable;
   assign bus2.penable = penable;
   assign bus3.penable = penable;
   assign bus0.pwrite = pwrite;
   assign bus2.pwrite = pwrite;
   assign bus3.pwrite = pwrite;
   assign bus0.paddr = paddr;
   assign bus2.paddr = paddr;
   assign bus3.paddr = paddr;
   assign bus0.pwdata = pwdata;
   assign bus2.pwdata = pwdata;
   assign bus3.pwdata = pwdata;
   assign bus0.pstrb = pstrb;
   assign bus2.pstrb = pstrb;
   assign bus3.pstrb = pstrb;

   apb_mem_slave_param #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_STATES(0)) dut0 (
      .pclk(pclk), .preset(preset), .bus(bus0.slave), .dbg_state(st0));
   apb_mem_slave_param #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_STATES(2)) dut2 (
      .pclk(pclk), .preset(preset), .bus(bus2.slave), .dbg_state(st2));
   apb_mem_slave_param #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_STATES(3)) dut3 (
      .pclk(pclk), .preset(preset), .bus(bus3.slave), .dbg_state(st3));

   logic        cur_pready;
   logic        cur_pslverr;
   logic [31:0] cur_prdata;

   always_comb begin
      cur_pready  = bus0.pready;
      cur_pslverr = bus0.pslverr;
      cur_prdata  = bus0.prdata;
      if (sel == 2) begin
         cur_pready  = bus2.pready;
         cur_pslverr = bus2.pslverr;
         cur_prdata  = bus2.prdata;
      end else if (sel == 3) begin
         cur_pready  = bus3.pready;
         cur_pslverr = bus3.pslverr;
         cur_prdata  = bus3.prdata;
      end
   end

   // clock / reset
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected done");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver: setup at a falling edge, enable at the next, hold until pready
   task automatic xfer(input int unsigned s, input logic w, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] sb,
                       output logic [31:0] rd, output logic er, output int cyc,
                       output logic to);
      @(negedge pclk);
      sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = sb;
      @(negedge pclk);
      penable = 1'b1;
      cyc = 1;
      to  = 1'b0;
      while (!cur_pready && !to) begin
         @(negedge pclk);
         cyc++;
         if (cyc > 40) to = 1'b1;
      end
      rd = cur_prdata;
      er = cur_pslverr;
   endtask

   task automatic bus_idle();
      @(negedge pclk);
      psel = 1'b0;
      penable = 1'b0;
   endtask

   typedef struct packed {
      logic        w;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   logic [31:0] rd;
   logic        er;
   logic        to;
   int          cyc;

   initial begin
      tests = 0; failed = 0;
      sel = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;

      vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 12'h020, 32'h11223344, 4'hF, 32'h0,        1'b0};
      vecs[3]  = '{1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
      vecs[4]  = '{1'b0, 12'h020, 32'h0,        4'hF, 32'h11BB33DD, 1'b0};
      vecs[5]  = '{1'b1, 12'h000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
      vecs[6]  = '{1'b1, 12'h400, 32'h12345678, 4'hF, 32'h0,        1'b1};
      vecs[7]  = '{1'b0, 12'h400, 32'h0,        4'h0, 32'h0,        1'b1};
      vecs[8]  = '{1'b0, 12'h000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      vecs[9]  = '{1'b1, 12'h008, 32'h5,        4'hF, 32'h0,        1'b0};
      vecs[10] = '{1'b0, 12'h008, 32'h0,        4'h0, 32'h5,        1'b0};
      vecs[11] = '{1'b0, 12'h013, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vecs[12] = '{1'b1, 12'h3FC, 32'h0000FFFF, 4'hF, 32'h0,        1'b0};
      vecs[13] = '{1'b0, 12'h3FC, 32'h0,        4'h0, 32'h0000FFFF, 1'b0};
      vecs[14] = '{1'b0, 12'hFFC, 32'h0,        4'h0, 32'h0,        1'b1};

      // reset state
      preset = 1'b1;
      repeat (3) @(negedge pclk);
      check("rst_pready", 64'(bus0.pready), 64'd0);
      check("rst_pslverr", 64'(bus0.pslverr), 64'd0);
      check("rst_prdata", 64'(bus0.prdata), 64'd0);
      check("rst_state", 64'(st0), 64'(IDLE));
      preset = 1'b0;

      // stray penable with no select, then penable without a setup phase
      penable = 1'b1;
      repeat (3) @(negedge pclk);
      check("stray_penable_pready", 64'(bus0.pready), 64'd0);
      check("stray_penable_state", 64'(st0), 64'(IDLE));
      sel = 0; psel = 1'b1;
      repeat (2) @(negedge pclk);
      check("nosetup_pready", 64'(bus0.pready), 64'd0);
      check("nosetup_state", 64'(st0), 64'(IDLE));
      bus_idle();

      // table: back-to-back transfers on the zero-wait slave
      for (int i = 0; i < NVEC; i++) begin
         xfer(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, rd, er, cyc, to);
         check($sformatf("vec%0d_timeout", i), 64'(to), 64'd0);
         check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'd2);
         check($sformatf("vec%0d_prdata", i), 64'(rd), 64'(vecs[i].exp_rd));
         check($sformatf("vec%0d_pslverr", i), 64'(er), 64'(vecs[i].exp_err));
      end
      bus_idle();

      // reset in the completion cycle of a write: outputs clear, write dropped
      xfer(0, 1'b1, 12'h010, 32'h00000077, 4'hF, rd, er, cyc, to);
      check("midrst_reached_ready", 64'(to), 64'd0);
      preset = 1'b1;
      #1;
      check("midrst_pready", 64'(bus0.pready), 64'd0);
      check("midrst_prdata", 64'(bus0.prdata), 64'd0);
      check("midrst_pslverr", 64'(bus0.pslverr), 64'd0);
      check("midrst_state", 64'(st0), 64'(IDLE));
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0; preset = 1'b0;
      xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, cyc, to);
      check("midrst_mem_kept", 64'(rd), 64'hDEADBEEF);
      bus_idle();

      // three wait states
      xfer(3, 1'b1, 12'h004, 32'h0BADCAFE, 4'hF, rd, er, cyc, to);
      check("ws3_wr_cycles", 64'(cyc), 64'd5);
      xfer(3, 1'b0, 12'h004, 32'h0, 4'h0, rd, er, cyc, to);
      check("ws3_rd_cycles", 64'(cyc), 64'd5);
      check("ws3_rd_prdata", 64'(rd), 64'h0BADCAFE);
      check("ws3_rd_pslverr", 64'(er), 64'd0);
      bus_idle();

      // abort with two wait states: psel dropped in ACCESS
      xfer(2, 1'b1, 12'h00C, 32'h00000011, 4'hF, rd, er, cyc, to);
      check("ws2_wr_cycles", 64'(cyc), 64'd4);
      bus_idle();
      @(negedge pclk);
      sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C;
      pwdata = 32'h9; pstrb = 4'hF;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      check("abort_access_state", 64'(st2), 64'(ACCESS));
      check("abort_access_pready", 64'(bus2.pready), 64'd0);
      psel = 1'b0;
      @(negedge pclk);
      check("abort_state", 64'(st2), 64'(IDLE));
      check("abort_pready", 64'(bus2.pready), 64'd0);
      penable = 1'b0;
      xfer(2, 1'b0, 12'h00C, 32'h0, 4'h0, rd, er, cyc, to);
      check("abort_mem_kept", 64'(rd), 64'h00000011);
      check("abort_rd_cycles", 64'(cyc), 64'd4);
      bus_idle();

      repeat (2) @(negedge pclk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
